// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs
//   Generic inter-stage pipeline register for the RV32I core. It moves a
//   payload and a control field between stages with a valid/ready handshake.
//   A two-entry arrangement (main + skid) lets in_ready come straight from a
//   flop while back-pressure never drops or duplicates an instruction.
//   A synchronous flush empties the stage and inserts a bubble. A saturating
//   counter records the cycles spent stalled by downstream.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       upstream presents an instruction
//   in_ready       stage can accept (registered, low only when skid is full)
//   in_data        upstream payload  [DATA_W]
//   in_ctrl        upstream control  [CTRL_W]
//   out_valid      stage holds a valid instruction
//   out_ready      downstream accepts
//   out_data       payload of head entry (holds last value while invalid)
//   out_ctrl       control of head entry, BUBBLE_CTRL while invalid
//   flush          discard held and incoming instructions this cycle
//   stall_clr      clear the stall counter
//   stall_cycles   saturating count of out_valid && !out_ready cycles
//   occupancy      number of held entries, 0..2
// ---------------------------------------------------------------------------
module pipe_stage_regs #(
    parameter int                DATA_W      = 96,
    parameter int                CTRL_W      = 13,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = 13'h0001,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [1:0]        occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign occupancy = state;

    // Main entry drives the outputs directly; the skid entry only catches the
    // one extra instruction accepted while in_ready was still high when
    // downstream stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= BUBBLE_CTRL;
            skid_data <= '0;
            skid_ctrl <= BUBBLE_CTRL;
            in_ready  <= 1'b1;
        end else if (flush) begin
            // Any in_fire this cycle is dropped; out_data keeps its value.
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_ctrl  <= BUBBLE_CTRL;
            skid_data <= '0;
            skid_ctrl <= BUBBLE_CTRL;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_ctrl  <= in_ctrl;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_data <= in_data;
                        out_ctrl <= in_ctrl;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= BUBBLE_CTRL;
                    end else if (in_fire) begin
                        state     <= FULL;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        in_ready  <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so nothing can arrive.
                    if (out_fire) begin
                        state     <= ONE;
                        out_data  <= skid_data;
                        out_ctrl  <= skid_ctrl;
                        skid_data <= '0;
                        skid_ctrl <= BUBBLE_CTRL;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    out_ctrl  <= BUBBLE_CTRL;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Stall counter: clear wins over increment, saturates at all-ones,
    // unaffected by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_clr) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 13;
    localparam int CNT_W  = 4;
    localparam logic [CTRL_W-1:0] BUB = 13'h0001;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush = 1'b0;
    logic              stall_clr = 1'b0;
    logic [CNT_W-1:0]  stall_cycles;
    logic [1:0]        occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_regs #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_CTRL(BUB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .stall_clr(stall_clr), .stall_cycles(stall_cycles), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: a FIFO of at most two entries.
    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] m_last = '0;
    int                m_cnt = 0;

    always @(posedge clk) begin
        bit inf;
        bit outf;
        if (!rst_n) begin
            q.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            inf  = in_valid && (q.size() < 2);
            outf = out_ready && (q.size() > 0);
            if (stall_clr) m_cnt = 0;
            else if (q.size() > 0 && !out_ready && m_cnt < CMAX) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (outf) void'(q.pop_front());
                if (inf) q.push_back('{in_data, in_ctrl});
            end
            if (q.size() > 0) m_last = q[0].d;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("occupancy", occupancy, q.size());
            chk("out_data", out_data, m_last);
            if (q.size() > 0) chk("out_ctrl", out_ctrl, q[0].c);
            else              chk("out_ctrl", out_ctrl, BUB);
            chk("stall_cycles", stall_cycles, m_cnt);
        end
    end

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit rdy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = d[CTRL_W-1:0] ^ 13'h0A50;
        out_ready = rdy;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_ctrl", out_ctrl, BUB);
        chk("rst in_ready", in_ready, 1);
        chk("rst occupancy", occupancy, 0);
        chk("rst stall", stall_cycles, 0);
        rst_n = 1'b1;

        // One-cycle latency
        drive(1, 96'h1, 1);
        @(negedge clk);
        chk("lat out_valid", out_valid, 1);
        chk("lat out_data", out_data, 96'h1);
        chk("lat occupancy", occupancy, 1);
        chk("lat in_ready", in_ready, 1);
        drive(0, 0, 1);
        @(negedge clk);

        // Fill to FULL under back-pressure, then drain in order
        drive(1, 96'h10, 0);
        @(negedge clk); drive(1, 96'h11, 0);
        @(negedge clk);
        chk("full occupancy", occupancy, 2);
        chk("full in_ready", in_ready, 0);
        chk("full head", out_data, 96'h10);
        drive(1, 96'h12, 0);
        @(negedge clk);
        chk("drain0 data", out_data, 96'h10);
        chk("drain0 occ", occupancy, 2);
        drive(1, 96'h12, 1);
        @(negedge clk);
        chk("drain1 data", out_data, 96'h11);
        chk("drain1 occ", occupancy, 1);
        @(negedge clk);
        chk("drain2 data", out_data, 96'h12);
        chk("drain2 occ", occupancy, 1);
        drive(0, 0, 1);
        @(negedge clk);
        chk("drain3 occ", occupancy, 0);
        chk("drain3 valid", out_valid, 0);

        // Flush from FULL, then flush from ONE with a concurrent in_fire
        drive(1, 96'h20, 0);
        @(negedge clk); drive(1, 96'h21, 0);
        @(negedge clk); drive(1, 96'h22, 0); flush = 1'b1;
        @(negedge clk);
        chk("flush valid", out_valid, 0);
        chk("flush ctrl", out_ctrl, BUB);
        chk("flush occ", occupancy, 0);
        chk("flush in_ready", in_ready, 1);
        flush = 1'b0; drive(1, 96'h23, 0);
        @(negedge clk);
        chk("post-flush head", out_data, 96'h23);
        drive(1, 96'h24, 1); flush = 1'b1;
        @(negedge clk);
        chk("flush1 occ", occupancy, 0);
        flush = 1'b0; drive(0, 0, 1);
        @(negedge clk);

        // Stall counter saturation and clear
        drive(1, 96'h30, 0); stall_clr = 1'b1;
        @(negedge clk);
        chk("sat clr", stall_cycles, 0);
        drive(0, 0, 0); stall_clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("sat value", stall_cycles, 15);
        stall_clr = 1'b1;
        @(negedge clk);
        chk("sat clr2", stall_cycles, 0);
        stall_clr = 1'b0;
        @(negedge clk);
        chk("sat inc", stall_cycles, 1);
        drive(0, 0, 1);
        @(negedge clk);

        // Asynchronous reset mid-stream
        drive(1, 96'h40, 0);
        @(negedge clk); drive(1, 96'h41, 0);
        @(negedge clk);
        chk("pre-rst occ", occupancy, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", out_valid, 0);
        chk("arst out_ctrl", out_ctrl, BUB);
        chk("arst out_data", out_data, 0);
        chk("arst in_ready", in_ready, 1);
        chk("arst occ", occupancy, 0);
        drive(0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0,
                  {$urandom, $urandom, $urandom},
                  $urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            stall_clr = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        drive(0, 0, 1); flush = 1'b0; stall_clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
Parametrised inter-stage pipeline register for the RV32I core. It is the generic successor to the fixed per-stage register banks. It carries a data payload and a control field between stages, with a valid/ready handshake and a two-entry skid buffer, so back-pressure never drops or duplicates an instruction. It adds a synchronous flush that inserts a bubble, and a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 96, payload width in bits (e.g. pc4, c, d concatenated)
CTRL_W, 13, control field width (e.g. rd, opcode, wr_reg_n)
BUBBLE_CTRL, 13'h0001, control value presented whenever the stage holds no valid instruction (bit0 = wr_reg_n = 1, no write)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept; registered, equals !skid_valid
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control
out_valid  output  1  stage holds a valid instruction
out_ready  input  1  downstream accepts
out_data  output  DATA_W  payload of head entry
out_ctrl  output  CTRL_W  control of head entry; BUBBLE_CTRL when out_valid=0
flush  input  1  discard all held and incoming instructions this cycle
stall_clr  input  1  clear stall counter
stall_cycles  output  CNT_W  saturating count of cycles with out_valid && !out_ready
occupancy  output  2  number of valid entries, 0..2

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL, skid cleared, in_ready=1, occupancy=0, stall_cycles=0.
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
- EMPTY: in_fire -> ONE, main<=in. Latency in->out is 1 cycle.
- ONE: in_fire && out_fire -> ONE, main<=in. out_fire only -> EMPTY. in_fire only -> FULL, skid<=in. Neither -> hold.
- FULL: in_ready=0. out_fire -> ONE, main<=skid. Else hold.
- Order is strictly FIFO. No entry is lost or duplicated under any out_ready pattern.
- Flush has top priority: next state EMPTY, skid cleared, out_valid=0, out_ctrl=BUBBLE_CTRL. An in_fire in the same cycle is discarded. in_ready=1 the cycle after.
- When out_valid=0, out_ctrl=BUBBLE_CTRL and out_data holds its last value. Consumers must not use out_data when out_valid=0.
- out_data and out_ctrl are stable while out_valid && !out_ready.
- stall_cycles increments on each cycle with out_valid && !out_ready and saturates at all-ones. stall_clr has priority over increment; the counter reads 0 the next cycle. Flush does not affect the counter.
- in_ready is driven directly from a flop and has no combinational path from out_ready.
- occupancy reflects the registered state: 0, 1 or 2.
- Reset asserted mid-transfer returns all state immediately to reset values; in-flight entries are lost.

Test Plan:
- Reset, then in_valid=1, in_data=0x1, out_ready=1 -> next cycle out_valid=1, out_data=0x1, occupancy=1; in_ready stays 1.
- Stream 0x10,0x11,0x12 with out_ready held 0 -> after 2 accepts occupancy=2, in_ready=0. 0x12 is held upstream. stall_cycles counts each cycle.
- From FULL, raise out_ready for 3 cycles -> outputs 0x10,0x11,0x12 in order, each exactly once; occupancy 2->1->1->0.
- From FULL with in_valid=1, pulse flush -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0, in_ready=1; the flushed-cycle input never appears.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles=15 (saturated). Then stall_clr with the stall persisting -> 0, then increments to 1.
- Assert rst_n=0 mid-stream (occupancy=2) -> out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, in_ready=1 immediately, without waiting for a clock edge.
